// File: rtl/lcd_sched_pkg.sv
// Shared constants and helpers for the LCD write scheduler.
// Source encodings, default sizing and a constant log2 for pointer widths.
package lcd_sched_pkg;

   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_KBD = 1'b1;

   localparam int DEF_DEPTH    = 8;
   localparam int DEF_CHAR_GAP = 64;

   // Smallest r with 2**r >= v; returns 1 for v <= 2 so widths never collapse to zero.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lcd_sched_fifo.sv
// Synchronous show-ahead FIFO of bytes; the level counter is kept separately from
// the wrapping pointers so that full and empty are never ambiguous.
module lcd_sched_fifo
   import lcd_sched_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   localparam int PTR_W = clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic [7:0]       push_data,
   input  logic             pop,
   output logic [7:0]       head,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_reg == LVL_W'(DEPTH));
   assign empty   = (level_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];
   assign level   = level_reg;

   // Storage carries no reset; only the pointers and level define validity.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Shares the LCD character-write port between the processor and the PS2 echo path:
// per-source hold registers, round-robin push into a FIFO, paced drain to the LCD.
module lcd_write_scheduler
   import lcd_sched_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int CHAR_GAP = DEF_CHAR_GAP
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       cpu_wr_en,
   input  logic [7:0] cpu_wr_data,
   input  logic       kbd_pressed,
   input  logic [7:0] kbd_data,
   input  logic       kbd_echo_en,
   input  logic       ovf_clr,
   output logic       lcd_write_en,
   output logic [7:0] lcd_write_data,
   output logic [3:0] fifo_level,
   output logic       overflow,
   output logic       busy
);

   localparam int LVL_W  = clog2(DEPTH) + 1;
   localparam int PACE_W = clog2(CHAR_GAP);

   logic              cpu_hold_valid_reg;
   logic [7:0]        cpu_hold_data_reg;
   logic              kbd_hold_valid_reg;
   logic [7:0]        kbd_hold_data_reg;
   logic              kbd_prev_reg;
   logic              rr_reg;
   logic              rr_next;
   logic [PACE_W-1:0] pace_reg;
   logic              lcd_write_en_reg;
   logic [7:0]        lcd_write_data_reg;
   logic              overflow_reg;

   logic              cpu_req;
   logic              kbd_req;
   logic              push_cpu;
   logic              push_kbd;
   logic              fifo_push;
   logic [7:0]        fifo_push_data;
   logic              fifo_pop;
   logic [7:0]        fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_level_w;
   logic              cpu_drop;
   logic              kbd_drop;

   assign cpu_req = cpu_wr_en;
   assign kbd_req = kbd_pressed && !kbd_prev_reg && kbd_echo_en;

   // rr only moves when both holds compete for the same push slot.
   always_comb begin
      push_cpu = 1'b0;
      push_kbd = 1'b0;
      rr_next  = rr_reg;
      if (!fifo_full) begin
         if (cpu_hold_valid_reg && kbd_hold_valid_reg) begin
            if (rr_reg == SRC_CPU) push_cpu = 1'b1;
            else                   push_kbd = 1'b1;
            rr_next = ~rr_reg;
         end else if (cpu_hold_valid_reg) begin
            push_cpu = 1'b1;
         end else if (kbd_hold_valid_reg) begin
            push_kbd = 1'b1;
         end
      end
   end

   assign fifo_push      = push_cpu || push_kbd;
   assign fifo_push_data = push_cpu ? cpu_hold_data_reg : kbd_hold_data_reg;
   assign fifo_pop       = !fifo_empty && (pace_reg == '0);
   assign cpu_drop       = cpu_req && cpu_hold_valid_reg && !push_cpu;
   assign kbd_drop       = kbd_req && kbd_hold_valid_reg && !push_kbd;

   lcd_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level_w)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cpu_hold_valid_reg <= 1'b0;
         cpu_hold_data_reg  <= '0;
         kbd_hold_valid_reg <= 1'b0;
         kbd_hold_data_reg  <= '0;
         kbd_prev_reg       <= 1'b0;
         rr_reg             <= SRC_CPU;
         pace_reg           <= '0;
         lcd_write_en_reg   <= 1'b0;
         lcd_write_data_reg <= '0;
         overflow_reg       <= 1'b0;
      end else begin
         kbd_prev_reg <= kbd_pressed;
         rr_reg       <= rr_next;

         // A hold freed by this cycle's push can take a new byte on the same edge.
         if (cpu_req && !cpu_drop) begin
            cpu_hold_valid_reg <= 1'b1;
            cpu_hold_data_reg  <= cpu_wr_data;
         end else if (push_cpu) begin
            cpu_hold_valid_reg <= 1'b0;
         end

         if (kbd_req && !kbd_drop) begin
            kbd_hold_valid_reg <= 1'b1;
            kbd_hold_data_reg  <= kbd_data;
         end else if (push_kbd) begin
            kbd_hold_valid_reg <= 1'b0;
         end

         if (cpu_drop || kbd_drop) overflow_reg <= 1'b1;
         else if (ovf_clr)         overflow_reg <= 1'b0;

         lcd_write_en_reg <= fifo_pop;
         if (fifo_pop) begin
            lcd_write_data_reg <= fifo_head;
            pace_reg           <= PACE_W'(CHAR_GAP - 1);
         end else if (pace_reg != '0) begin
            pace_reg <= pace_reg - PACE_W'(1);
         end
      end
   end

   assign lcd_write_en   = lcd_write_en_reg;
   assign lcd_write_data = lcd_write_data_reg;
   assign fifo_level     = 4'(fifo_level_w);
   assign overflow       = overflow_reg;
   assign busy           = cpu_hold_valid_reg || kbd_hold_valid_reg || !fifo_empty
                           || (pace_reg != '0);

endmodule
